// File: rtl/zbt_frame_arbiter.sv
// rtl/zbt_frame_arbiter.sv - single-port ZBT arbiter for VGA, camera and transform requesters
module zbt_frame_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 36,
    parameter int ZBT_LATENCY  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_enable,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_gnt,
    output logic              v_rvalid,
    output logic [DATA_W-1:0] v_rdata,
    input  logic              c_req,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    input  logic              t_req,
    input  logic              t_we,
    input  logic [ADDR_W-1:0] t_addr,
    input  logic [DATA_W-1:0] t_wdata,
    output logic              t_gnt,
    output logic              t_rvalid,
    output logic [DATA_W-1:0] t_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam int TAG_D = ZBT_LATENCY + 1;

    logic [SW-1:0]    starve_cnt;
    logic [TAG_D-1:0] v_tag;
    logic [TAG_D-1:0] t_tag;
    logic             t_force;
    logic             c_elig;

    always_comb begin
        v_gnt   = 1'b0;
        c_gnt   = 1'b0;
        t_gnt   = 1'b0;
        c_elig  = c_req & cam_enable;
        t_force = t_req && (starve_cnt == SW'(STARVE_LIMIT));
        if (!reset) begin
            if (t_force)     t_gnt = 1'b1;
            else if (v_req)  v_gnt = 1'b1;
            else if (c_elig) c_gnt = 1'b1;
            else if (t_req)  t_gnt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            v_tag      <= '0;
            t_tag      <= '0;
        end else begin
            if (t_gnt || !t_req)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;

            mem_we <= c_gnt | (t_gnt & t_we);
            // Write data only moves on writes; reads and idle cycles leave the bus parked.
            if (v_gnt) begin
                mem_addr <= v_addr;
            end else if (c_gnt) begin
                mem_addr  <= c_addr;
                mem_wdata <= c_wdata;
            end else if (t_gnt) begin
                mem_addr <= t_addr;
                if (t_we)
                    mem_wdata <= t_wdata;
            end

            v_tag <= {v_tag[TAG_D-2:0], v_gnt};
            t_tag <= {t_tag[TAG_D-2:0], t_gnt & ~t_we};
        end
    end

    assign v_rvalid = v_tag[TAG_D-1];
    assign t_rvalid = t_tag[TAG_D-1];
    assign v_rdata  = mem_rdata;
    assign t_rdata  = mem_rdata;

endmodule

// File: tb/tb_zbt_frame_arbiter.sv
// tb/tb_zbt_frame_arbiter.sv - randomized and directed bench for zbt_frame_arbiter
module tb_zbt_frame_arbiter;

    logic        clk = 1'b0;
    logic        reset, cam_enable;
    logic        v_req, c_req, t_req, t_we;
    logic [18:0] v_addr, c_addr, t_addr;
    logic [35:0] c_wdata, t_wdata, mem_rdata;
    logic        v_gnt, v_rvalid, c_gnt, t_gnt, t_rvalid, mem_we;
    logic [35:0] v_rdata, t_rdata, mem_wdata;
    logic [18:0] mem_addr;

    zbt_frame_arbiter dut (
        .clk(clk), .reset(reset), .cam_enable(cam_enable),
        .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
        .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt),
        .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata), .t_gnt(t_gnt),
        .t_rvalid(t_rvalid), .t_rdata(t_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference state: starvation count, expected memory bus, read-return schedule by cycle
    int          starve = 0;
    bit          mem_known = 0;
    bit          exp_we = 0;
    logic [18:0] exp_addr = '0;
    logic [35:0] exp_wdata = '0;
    bit          sched_v[0:4095];
    bit          sched_t[0:4095];

    logic        s_v_gnt, s_c_gnt, s_t_gnt, s_v_rvalid, s_t_rvalid, s_mem_we;
    logic [18:0] s_mem_addr;
    logic [35:0] s_mem_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        int w;
        @(negedge clk);
        s_v_gnt = v_gnt; s_c_gnt = c_gnt; s_t_gnt = t_gnt;
        s_v_rvalid = v_rvalid; s_t_rvalid = t_rvalid;
        s_mem_we = mem_we; s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;

        w = 0;
        if (!reset) begin
            if (t_req && starve == 8)      w = 3;
            else if (v_req)                w = 1;
            else if (c_req && cam_enable)  w = 2;
            else if (t_req)                w = 3;
        end
        chk("v_gnt", v_gnt, w == 1);
        chk("c_gnt", c_gnt, w == 2);
        chk("t_gnt", t_gnt, w == 3);
        if (!reset) begin
            if (mem_known) begin
                chk("mem_we", mem_we, exp_we);
                chk("mem_addr", mem_addr, exp_addr);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
            chk("v_rvalid", v_rvalid, sched_v[cyc]);
            chk("t_rvalid", t_rvalid, sched_t[cyc]);
            if (sched_v[cyc]) chk("v_rdata", v_rdata, mem_rdata);
            if (sched_t[cyc]) chk("t_rdata", t_rdata, mem_rdata);
        end

        if (reset) begin
            starve = 0;
            mem_known = 1;
            exp_we = 0; exp_addr = '0; exp_wdata = '0;
            for (int k = 1; k <= 3; k++) begin
                sched_v[cyc+k] = 0;
                sched_t[cyc+k] = 0;
            end
        end else begin
            starve = (t_req && w != 3) ? ((starve < 8) ? starve + 1 : 8) : 0;
            exp_we = (w == 2) || (w == 3 && t_we);
            if (w == 1) begin
                exp_addr = v_addr;
                sched_v[cyc+3] = 1;
            end else if (w == 2) begin
                exp_addr = c_addr; exp_wdata = c_wdata;
            end else if (w == 3) begin
                exp_addr = t_addr;
                if (t_we) exp_wdata = t_wdata;
                else      sched_t[cyc+3] = 1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        mem_rdata = 36'({$urandom, $urandom});
    endtask

    task automatic idle();
        v_req = 0; c_req = 0; t_req = 0;
        step();
    endtask

    int got, got2, cnt_c, cnt_we;
    bit v_after;

    initial begin
        reset = 1; cam_enable = 1; v_req = 0; c_req = 0; t_req = 0; t_we = 0;
        v_addr = '0; c_addr = '0; t_addr = '0; c_wdata = '0; t_wdata = '0; mem_rdata = '0;
        @(posedge clk); #1;
        step(); step();
        reset = 0;
        idle();
        chk("reset_mem_we", s_mem_we, 0);
        chk("reset_mem_addr", s_mem_addr, 0);
        chk("reset_mem_wdata", s_mem_wdata, 0);
        chk("reset_rvalid", {s_v_rvalid, s_t_rvalid}, 0);

        // single VGA read
        v_req = 1; v_addr = 19'h00010;
        step(); chk("t1_v_gnt", s_v_gnt, 1);
        v_req = 0;
        step(); chk("t1_mem_addr", s_mem_addr, 19'h00010); chk("t1_mem_we", s_mem_we, 0);
        step();
        step(); chk("t1_v_rvalid", s_v_rvalid, 1);
        idle(); idle();

        // fixed priority V > C > T
        v_req = 1; c_req = 1; t_req = 1; t_we = 1; cam_enable = 1;
        c_addr = 19'h00aaa; c_wdata = 36'h123456789; t_addr = 19'h00bbb; t_wdata = 36'hfedcba987;
        step(); chk("t2_v_only", {s_v_gnt, s_c_gnt, s_t_gnt}, 3'b100);
        v_req = 0;
        step(); chk("t2_c_next", {s_v_gnt, s_c_gnt, s_t_gnt}, 3'b010);
        c_req = 0;
        step(); chk("t2_t_last", {s_v_gnt, s_c_gnt, s_t_gnt}, 3'b001);
        idle(); idle(); idle(); idle();

        // starvation override
        v_req = 1; c_req = 1; t_req = 1; t_we = 0;
        got = 0; got2 = 0; v_after = 0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (s_t_gnt && got == 0) got = i;
            else if (s_t_gnt && got2 == 0) got2 = i;
            if (i == 10) v_after = s_v_gnt;
        end
        chk("t3_first_t_gnt_cycle", got, 9);
        chk("t3_v_wins_after", v_after, 1);
        chk("t3_second_t_gnt_cycle", got2, 18);
        idle(); idle(); idle(); idle();

        // camera frozen
        cam_enable = 0; c_req = 1; c_addr = 19'h12345;
        cnt_c = 0; cnt_we = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt_c += s_c_gnt;
            cnt_we += s_mem_we;
        end
        chk("t4_c_gnt_count", cnt_c, 0);
        chk("t4_mem_we_count", cnt_we, 0);
        c_req = 0; cam_enable = 1;
        idle();

        // T read then V read: returns in order, to the right port
        t_req = 1; t_we = 0; t_addr = 19'h01234;
        step(); chk("t5_t_gnt", s_t_gnt, 1);
        t_req = 0; v_req = 1; v_addr = 19'h04321;
        step(); chk("t5_v_gnt", s_v_gnt, 1);
        v_req = 0;
        step();
        step(); chk("t5_t_ret", {s_v_rvalid, s_t_rvalid}, 2'b01);
        step(); chk("t5_v_ret", {s_v_rvalid, s_t_rvalid}, 2'b10);
        idle(); idle();

        // reset drops an in-flight read
        t_req = 1; t_we = 0; t_addr = 19'h00777;
        step(); chk("t6_t_gnt", s_t_gnt, 1);
        t_req = 0; reset = 1;
        step();
        reset = 0;
        step();
        chk("t6_zero_gnt", {s_v_gnt, s_c_gnt, s_t_gnt}, 0);
        chk("t6_zero_rvalid", {s_v_rvalid, s_t_rvalid}, 0);
        chk("t6_zero_mem", {s_mem_we, s_mem_addr, s_mem_wdata}, 0);
        step(); chk("t6_no_t_rvalid", s_t_rvalid, 0);
        idle(); idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            cam_enable = ($urandom_range(0, 3) != 0);
            v_req      = $urandom_range(0, 1);
            c_req      = ($urandom_range(0, 9) < 6);
            t_req      = ($urandom_range(0, 9) < 6);
            t_we       = $urandom_range(0, 1);
            v_addr     = 19'($urandom);
            c_addr     = 19'($urandom);
            t_addr     = 19'($urandom);
            c_wdata    = 36'({$urandom, $urandom});
            t_wdata    = 36'({$urandom, $urandom});
            step();
        end
        reset = 0;
        for (int i = 0; i < 5; i++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
